// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, I/O addresses and default frame geometry
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for the asynchronous serial line, resets to idle-high
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - oversampling 8N1 UART receiver with holding register and bus-readable status
module uart_receive
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 brg_en,
    input  logic                 rxd,
    input  logic                 iocs,
    input  logic                 iorw,
    input  logic [1:0]           ioaddr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int              TW       = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]   TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]   TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]      BIT_LAST = 4'(DATA_BITS - 1);

    rx_state_t              state, state_nxt;
    logic [TW-1:0]          tick_cnt, tick_nxt;
    logic [3:0]             bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0]   shreg, shreg_nxt;
    logic                   load;
    logic                   rd;
    logic                   rxd_s;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign rd = iocs & iorw & (ioaddr == ADDR_DATA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
        end
    end

    // Everything advances only on baud ticks, so a stalled generator freezes the frame in place.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        load      = 1'b0;
        if (brg_en) begin
            case (state)
                IDLE: begin
                    tick_nxt = '0;
                    if (!rxd_s) state_nxt = START;
                end
                START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_nxt  = '0;
                        bit_nxt   = '0;
                        state_nxt = rxd_s ? IDLE : DATA;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == TICK_END) begin
                        shreg_nxt = {rxd_s, shreg[DATA_BITS-1:1]};
                        tick_nxt  = '0;
                        bit_nxt   = bit_cnt + 4'd1;
                        if (bit_cnt == BIT_LAST) state_nxt = STOP;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == TICK_END) begin
                        load      = 1'b1;
                        tick_nxt  = '0;
                        state_nxt = IDLE;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A load beats a coincident read: the new byte stays available and is not counted as lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data   <= '0;
            rda       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (load) begin
            rx_data   <= shreg;
            frame_err <= ~rxd_s;
            rda       <= 1'b1;
            overrun   <= rd ? 1'b0 : (overrun | rda);
        end else if (rd) begin
            rda     <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule
